mips_irq_controller: RTL and testbench
======================================

# mips_irq_controller

Priority interrupt controller that sits directly upstream of the 16-bit MIPS processor and drives its single-bit `interrupt` input. It edge-detects up to four external request lines, latches them as pending, applies a software-writable mask, and presents the highest-priority unmasked request. A request/acknowledge/done handshake with the processor core also supplies a 16-bit handler vector for the PC mux.

## Interface
- `NUM_IRQ`, 4: number of request lines (1–8).
- `VEC_BASE`, 16'h0040: handler address of IRQ 0.
- `VEC_STRIDE`, 16'h0010: address step between consecutive handlers.
- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `irq_in`  in  NUM_IRQ  external request lines, rising-edge significant.
- `mask_wr`  in  1  load `mask_in` into mask register this cycle.
- `mask_in`  in  NUM_IRQ  new mask; 1 = enabled.
- `int_ack`  in  1  core has taken the interrupt; one-cycle pulse.
- `int_done`  in  1  core finished the handler (return-from-interrupt); one-cycle pulse.
- `interrupt`  out  1  request to the core.
- `irq_id`  out  3  index of presented/serviced request.
- `vector`  out  16  `VEC_BASE + irq_id*VEC_STRIDE`, valid while `interrupt` or `busy`.
- `pending`  out  NUM_IRQ  pending register, for debug visibility.
- `busy`  out  1  handler in progress.

## Operation
- Reset (`reset`=0): `interrupt`=0, `irq_id`=0, `vector`=`VEC_BASE`, `pending`=0, `busy`=0, mask=0 (all disabled), edge history=0, state IDLE.
- Edge detect: `pending[i]` is set when the sampled `irq_in[i]` is 1 and its previous sample was 0. Levels held high set `pending` only once.
- Pending bits are set regardless of mask. Masked bits stay pending until they are unmasked and serviced.
- Selection: the lowest index among `pending & mask` wins.
- FSM states and transitions:
  - IDLE → REQ when `pending & mask` ≠ 0. Latch the winner into `irq_id` and assert `interrupt`.
  - REQ → SERVICE on `int_ack`. Clear `pending[irq_id]`, deassert `interrupt`, assert `busy`.
  - REQ → IDLE when `mask[irq_id]` becomes 0 before ack. Deassert `interrupt`; the pending bit is retained.
  - SERVICE → IDLE on `int_done`. Clear `busy`.
- No nesting: requests arriving in REQ or SERVICE only set `pending`. Re-selection happens from IDLE.
- A higher-priority request arriving while in REQ does not change `irq_id`; the latched winner is held until ack.
- Simultaneous new edge on `irq_id` and `int_ack`: set wins, so the pending bit stays 1 and is serviced again later.
- `int_ack` outside REQ and `int_done` outside SERVICE are ignored.
- `mask_wr` takes effect on the next edge. It never clears `pending`.

## Timing
- `irq_in[i]` rises before edge N → `pending[i]`=1 after edge N → `interrupt`=1 after edge N+1. That is two-cycle latency without the synchronizer.
- `int_ack` sampled at edge M → `interrupt`=0 and `busy`=1 after edge M.
- `int_done` at edge K → IDLE after edge K. The next interrupt is asserted at the earliest after edge K+1.
- `vector` and `irq_id` are registered and change only on entry to REQ.
- Reset asserted mid-handshake returns the block to its reset values immediately, without waiting for a clock edge.

## Configuration
- `MIPS_IRQ_SYNC_EN`
  - Defined: each `irq_in` bit passes through a two-flop synchronizer (reset to 0) before edge detection. Latency from `irq_in` to `interrupt` becomes four cycles.
  - Undefined: `irq_in` is assumed synchronous to `clk` and is sampled directly. Latency is two cycles.

## Structure
- Package `mips_irq_pkg`:
  - state enum `irq_state_t` {IDLE, REQ, SERVICE};
  - default `VEC_BASE`/`VEC_STRIDE` constants;
  - function `irq_prio_enc` (lowest-set-bit encoder).
- Sub-module `mips_irq_edge_detect`: the optional synchronizer plus previous-sample register plus rise pulse, `NUM_IRQ` wide.
- Top level holds the FSM, mask and pending registers, and the vector adder.

## Test plan
- Single IRQ: mask=4'b0100, pulse `irq_in[2]` → `interrupt`=1 two cycles later, `irq_id`=2, `vector`=16'h0060. `int_ack` → `pending[2]`=0, `busy`=1. `int_done` → IDLE.
- Priority: raise `irq_in[3]` and `irq_in[1]` together, mask=4'hF → `irq_id`=1 first. After done, `irq_id`=3, `vector`=16'h0070.
- Masked pending: mask=0, pulse `irq_in[0]` → `pending`=4'b0001, `interrupt` stays 0. Write mask=4'h1 → `interrupt`=1 one cycle after the mask takes effect.
- Race: new `irq_in[1]` edge coincides with `int_ack` for `irq_id`=1 → `pending[1]` stays 1 and IRQ 1 is re-presented after `int_done`.
- Unmask-withdraw: in REQ for IRQ 2, write mask=0 → `interrupt`=0 next cycle, `pending[2]`=1 retained.
- Reset mid-SERVICE: drive `reset`=0 asynchronously → `busy`, `interrupt`, `pending` and mask are 0 immediately. With `MIPS_IRQ_SYNC_EN` defined, verify four-cycle latency.

Source files
------------

// File: rtl/mips_irq_pkg.sv
// Shared types and helpers for the MIPS priority interrupt controller.
package mips_irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

  localparam logic [15:0] DEF_VEC_BASE   = 16'h0040;
  localparam logic [15:0] DEF_VEC_STRIDE = 16'h0010;
  localparam int          MAX_IRQ        = 8;

  // Lowest set bit wins; returns 0 when nothing is set.
  function automatic logic [2:0] irq_prio_enc(input logic [MAX_IRQ-1:0] req);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = MAX_IRQ - 1; i >= 0; i--) begin
      if (req[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mips_irq_controller_if.sv
// Request/acknowledge/done handshake between the interrupt controller and the core.
interface mips_irq_controller_if;
  logic        interrupt;
  logic [2:0]  irq_id;
  logic [15:0] vector;
  logic        busy;
  logic        int_ack;
  logic        int_done;

  modport master (
    output interrupt, irq_id, vector, busy,
    input  int_ack, int_done
  );

  modport slave (
    input  interrupt, irq_id, vector, busy,
    output int_ack, int_done
  );
endinterface

// File: rtl/mips_irq_edge_detect.sv
// Per-line rise detector; with MIPS_IRQ_SYNC_EN defined each line first passes
// through a two-flop synchronizer.
module mips_irq_edge_detect #(
  parameter int NUM_IRQ = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic [NUM_IRQ-1:0] rise
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IRQ; gi++) begin : g_bit
      logic sample;
      logic prev_reg;

`ifdef MIPS_IRQ_SYNC_EN
      logic sync1_reg;
      logic sync2_reg;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
        end else begin
          sync1_reg <= irq_in[gi];
          sync2_reg <= sync1_reg;
        end
      end

      assign sample = sync2_reg;
`else
      assign sample = irq_in[gi];
`endif

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) prev_reg <= 1'b0;
        else        prev_reg <= sample;
      end

      assign rise[gi] = sample & ~prev_reg;
    end
  endgenerate

endmodule

// File: rtl/mips_irq_controller.sv
// Priority interrupt controller feeding the 16-bit MIPS core: pending/mask
// registers, IDLE/REQ/SERVICE handshake FSM and handler vector. Option: MIPS_IRQ_SYNC_EN.
module mips_irq_controller
  import mips_irq_pkg::*;
#(
  parameter int          NUM_IRQ    = 4,
  parameter logic [15:0] VEC_BASE   = DEF_VEC_BASE,
  parameter logic [15:0] VEC_STRIDE = DEF_VEC_STRIDE
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_IRQ-1:0]       irq_in,
  input  logic                     mask_wr,
  input  logic [NUM_IRQ-1:0]       mask_in,
  mips_irq_controller_if.master    core,
  output logic [NUM_IRQ-1:0]       pending
);

  localparam logic [1:0] ST_IDLE    = 2'(IDLE);
  localparam logic [1:0] ST_REQ     = 2'(REQ);
  localparam logic [1:0] ST_SERVICE = 2'(SERVICE);

  logic [1:0]         state_reg,   state_next;
  logic [NUM_IRQ-1:0] pending_reg, pending_next;
  logic [NUM_IRQ-1:0] mask_reg;
  logic [2:0]         irq_id_reg,  irq_id_next;
  logic [15:0]        vector_reg,  vector_next;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] cand;
  logic [NUM_IRQ-1:0] id_onehot;
  logic [NUM_IRQ-1:0] clr;

  mips_irq_edge_detect #(.NUM_IRQ(NUM_IRQ)) u_edge (
    .clk    (clk),
    .reset  (reset),
    .irq_in (irq_in),
    .rise   (rise)
  );

  assign cand      = pending_reg & mask_reg;
  assign id_onehot = NUM_IRQ'(1) << irq_id_reg;

  always_comb begin
    state_next  = state_reg;
    irq_id_next = irq_id_reg;
    vector_next = vector_reg;
    clr         = '0;
    case (state_reg)
      ST_IDLE: begin
        if (|cand) begin
          state_next  = ST_REQ;
          irq_id_next = irq_prio_enc(8'(cand));
          vector_next = VEC_BASE + 16'(irq_id_next) * VEC_STRIDE;
        end
      end
      ST_REQ: begin
        // The winner stays latched until ack; an ack beats a same-cycle unmask.
        if (core.int_ack) begin
          state_next = ST_SERVICE;
          clr        = id_onehot;
        end else if (!(|(mask_reg & id_onehot))) begin
          state_next = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (core.int_done) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    // A fresh edge on the line being acked re-arms it.
    pending_next = (pending_reg & ~clr) | rise;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      pending_reg <= '0;
      mask_reg    <= '0;
      irq_id_reg  <= 3'd0;
      vector_reg  <= VEC_BASE;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      irq_id_reg  <= irq_id_next;
      vector_reg  <= vector_next;
      if (mask_wr) mask_reg <= mask_in;
    end
  end

  assign core.interrupt = (state_reg == ST_REQ);
  assign core.busy      = (state_reg == ST_SERVICE);
  assign core.irq_id    = irq_id_reg;
  assign core.vector    = vector_reg;
  assign pending        = pending_reg;

endmodule

// File: tb/tb_mips_irq_controller.sv
// Testbench for mips_irq_controller: directed vector table, reset/latency
// sequences and a randomized run against a behavioural model.
module tb_mips_irq_controller;
  import mips_irq_pkg::*;

  localparam int N = 4;
`ifdef MIPS_IRQ_SYNC_EN
  localparam int SYNC_STAGES = 2;
`else
  localparam int SYNC_STAGES = 0;
`endif
  localparam int LAT = 2 + SYNC_STAGES;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] irq_in;
  logic         mask_wr;
  logic [N-1:0] mask_in;
  logic [N-1:0] pending;

  mips_irq_controller_if core_if ();

  mips_irq_controller #(.NUM_IRQ(N)) dut (
    .clk     (clk),
    .reset   (reset),
    .irq_in  (irq_in),
    .mask_wr (mask_wr),
    .mask_in (mask_in),
    .core    (core_if),
    .pending (pending)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [N-1:0] m_pend, m_mask, m_prev;
  bit         m_req, m_busy;
  int         m_id;
  bit [N-1:0] m_line[$];

  task automatic model_reset();
    m_pend = '0; m_mask = '0; m_prev = '0;
    m_req  = 0;  m_busy = 0;  m_id = 0;
    m_line.delete();
    repeat (SYNC_STAGES) m_line.push_back('0);
  endtask

  task automatic model_eval();
    bit [N-1:0] samp, rise, nxt;
    bit found;
    m_line.push_back(irq_in);
    samp   = m_line.pop_front();
    rise   = samp & ~m_prev;
    m_prev = samp;
    nxt    = m_pend;
    if (m_req && core_if.int_ack) nxt[m_id] = 1'b0;
    nxt = nxt | rise;
    if (m_req) begin
      if (core_if.int_ack) begin m_req = 0; m_busy = 1; end
      else if (!m_mask[m_id]) m_req = 0;
    end else if (m_busy) begin
      if (core_if.int_done) m_busy = 0;
    end else begin
      found = 0;
      for (int i = N - 1; i >= 0; i--)
        if (m_pend[i] && m_mask[i]) begin m_id = i; found = 1; end
      if (found) m_req = 1;
    end
    m_pend = nxt;
    if (mask_wr) m_mask = mask_in;
  endtask

  function automatic logic [31:0] dut_pack();
    return 32'({core_if.interrupt, core_if.busy, core_if.irq_id, core_if.vector, pending});
  endfunction

  function automatic logic [31:0] model_pack();
    logic [15:0] v;
    v = 16'h0040 + 16'(m_id) * 16'h0010;
    return 32'({m_req, m_busy, 3'(m_id), v, m_pend});
  endfunction

  // One clock: model follows the inputs currently driven, then outputs are compared.
  task automatic step();
    model_eval();
    @(posedge clk);
    #1;
    check("model", dut_pack(), model_pack());
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [3:0] irq;
    logic       mwr;
    logic [3:0] mask;
    logic       ack, done;
    logic       e_int, e_busy;
    logic [2:0] e_id;
    logic [3:0] e_pend;
  } vec_t;

  function automatic vec_t mk(int irq, int mwr, int mask, int ack, int done,
                              int e_int, int e_busy, int e_id, int e_pend);
    vec_t v;
    v.irq = 4'(irq); v.mwr = 1'(mwr); v.mask = 4'(mask); v.ack = 1'(ack); v.done = 1'(done);
    v.e_int = 1'(e_int); v.e_busy = 1'(e_busy); v.e_id = 3'(e_id); v.e_pend = 4'(e_pend);
    return v;
  endfunction

  task automatic drive(input logic [N-1:0] irq, input logic mwr, input logic [N-1:0] mask,
                       input logic ack, input logic done);
    irq_in = irq; mask_wr = mwr; mask_in = mask;
    core_if.int_ack = ack; core_if.int_done = done;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    drive('0, 0, '0, 0, 0);
    reset = 1'b1;
    model_reset();
  endtask

  vec_t tbl[29];
  logic [15:0] exp_vec;
  int k;

  initial begin
    reset = 1'b0;
    drive('0, 0, '0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_values", dut_pack(), 32'({1'b0, 1'b0, 3'd0, 16'h0040, 4'h0}));
    @(negedge clk);
    reset = 1'b1;

`ifndef MIPS_IRQ_SYNC_EN
    //            irq mwr mask ack done | int busy id pend
    tbl[0]  = mk(4'h0, 1, 4'h4, 0, 0,   0, 0, 0, 4'h0);
    tbl[1]  = mk(4'h4, 0, 4'h0, 0, 0,   0, 0, 0, 4'h4);
    tbl[2]  = mk(4'h4, 0, 4'h0, 0, 0,   1, 0, 2, 4'h4);
    tbl[3]  = mk(4'h0, 0, 4'h0, 0, 0,   1, 0, 2, 4'h4);
    tbl[4]  = mk(4'h0, 0, 4'h0, 1, 0,   0, 1, 2, 4'h0);
    tbl[5]  = mk(4'h0, 0, 4'h0, 0, 0,   0, 1, 2, 4'h0);
    tbl[6]  = mk(4'h0, 0, 4'h0, 0, 1,   0, 0, 2, 4'h0);
    tbl[7]  = mk(4'hA, 1, 4'hF, 0, 0,   0, 0, 2, 4'hA);
    tbl[8]  = mk(4'hA, 0, 4'h0, 0, 0,   1, 0, 1, 4'hA);
    tbl[9]  = mk(4'hA, 0, 4'h0, 1, 0,   0, 1, 1, 4'h8);
    tbl[10] = mk(4'hA, 0, 4'h0, 0, 1,   0, 0, 1, 4'h8);
    tbl[11] = mk(4'hA, 0, 4'h0, 0, 0,   1, 0, 3, 4'h8);
    tbl[12] = mk(4'h0, 0, 4'h0, 1, 0,   0, 1, 3, 4'h0);
    tbl[13] = mk(4'h0, 0, 4'h0, 0, 1,   0, 0, 3, 4'h0);
    tbl[14] = mk(4'h0, 1, 4'h0, 0, 0,   0, 0, 3, 4'h0);
    tbl[15] = mk(4'h1, 0, 4'h0, 0, 0,   0, 0, 3, 4'h1);
    tbl[16] = mk(4'h0, 0, 4'h0, 0, 0,   0, 0, 3, 4'h1);
    tbl[17] = mk(4'h0, 1, 4'h1, 0, 0,   0, 0, 3, 4'h1);
    tbl[18] = mk(4'h0, 0, 4'h0, 0, 0,   1, 0, 0, 4'h1);
    tbl[19] = mk(4'h0, 0, 4'h0, 1, 0,   0, 1, 0, 4'h0);
    tbl[20] = mk(4'h0, 0, 4'h0, 0, 1,   0, 0, 0, 4'h0);
    tbl[21] = mk(4'h2, 1, 4'hF, 0, 0,   0, 0, 0, 4'h2);
    tbl[22] = mk(4'h0, 0, 4'h0, 0, 0,   1, 0, 1, 4'h2);
    tbl[23] = mk(4'h2, 0, 4'h0, 1, 0,   0, 1, 1, 4'h2);
    tbl[24] = mk(4'h0, 0, 4'h0, 0, 1,   0, 0, 1, 4'h2);
    tbl[25] = mk(4'h0, 0, 4'h0, 0, 0,   1, 0, 1, 4'h2);
    tbl[26] = mk(4'h0, 1, 4'h0, 0, 0,   1, 0, 1, 4'h2);
    tbl[27] = mk(4'h0, 0, 4'h0, 0, 0,   0, 0, 1, 4'h2);
    tbl[28] = mk(4'h0, 0, 4'h0, 1, 1,   0, 0, 1, 4'h2);

    @(posedge clk);
    #1;
    for (int i = 0; i < 29; i++) begin
      drive(tbl[i].irq, tbl[i].mwr, tbl[i].mask, tbl[i].ack, tbl[i].done);
      step();
      exp_vec = 16'h0040 + 16'(tbl[i].e_id) * 16'h0010;
      check($sformatf("row%0d", i), dut_pack(),
            32'({tbl[i].e_int, tbl[i].e_busy, tbl[i].e_id, exp_vec, tbl[i].e_pend}));
      $display("row %0d: irq=%b mwr=%b mask=%b ack=%b done=%b -> int=%b busy=%b id=%0d vec=%h pend=%b",
               i, tbl[i].irq, tbl[i].mwr, tbl[i].mask, tbl[i].ack, tbl[i].done,
               core_if.interrupt, core_if.busy, core_if.irq_id, core_if.vector, pending);
    end
`endif

    // Reset in the middle of SERVICE.
    do_reset();
    drive(4'h4, 1, 4'hF, 0, 0);
    step();
    drive(4'h4, 0, 4'h0, 0, 0);
    k = 0;
    while (!core_if.interrupt && k < 20) begin step(); k++; end
    check("reach_req", 32'(core_if.interrupt), 32'd1);
    drive(4'h4, 0, 4'h0, 1, 0);
    step();
    drive(4'h4, 0, 4'h0, 0, 0);
    check("in_service", 32'(core_if.busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async_reset", dut_pack(), 32'({1'b0, 1'b0, 3'd0, 16'h0040, 4'h0}));
    $display("async reset mid-service: busy=%b int=%b pend=%b", core_if.busy, core_if.interrupt, pending);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    drive(4'h1, 0, 4'h0, 0, 0);
    repeat (LAT + 2) step();
    check("mask_cleared_pend", 32'(pending), 32'h1);
    check("mask_cleared_int", 32'(core_if.interrupt), 32'd0);

    // Edge-to-interrupt latency.
    do_reset();
    drive(4'h0, 1, 4'hF, 0, 0);
    step();
    drive(4'h1, 0, 4'h0, 0, 0);
    k = 1;
    step();
    while (!core_if.interrupt && k < 20) begin step(); k++; end
    check("irq_latency", 32'(k), 32'(LAT));
    check("latency_vector", 32'(core_if.vector), 32'h0040);
    $display("latency: interrupt after %0d edges", k);

    // Randomized run against the model.
    for (int t = 0; t < 500; t++) begin
      irq_in   = irq_in ^ (($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
      mask_wr  = ($urandom_range(0, 15) == 0);
      mask_in  = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
      core_if.int_ack  = m_req  ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      core_if.int_done = m_busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
      if (m_req && core_if.int_ack)
        $display("rand t=%0d: ack irq %0d", t, m_id);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
